// File: rtl/cpu_branch_update_sched_if.sv
// Handshake bundle between the two branch requesters and the
// predictor update scheduler.
interface cpu_branch_update_sched_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                   req0_valid;
  logic [XLEN-1:0]        req0_addr;
  logic                   req0_taken;
  logic                   req0_ready;
  logic                   req1_valid;
  logic [XLEN-1:0]        req1_addr;
  logic                   req1_taken;
  logic                   req1_ready;
  logic                   hold;
  logic                   flush;
  logic                   update;
  logic [XLEN-1:0]        update_addr;
  logic                   update_taken;
  logic [$clog2(DEPTH):0] pending;

  modport master (
    output req0_valid, req0_addr, req0_taken,
    input  req0_ready,
    output req1_valid, req1_addr, req1_taken,
    input  req1_ready,
    output hold, flush,
    input  update, update_addr, update_taken, pending
  );

  modport slave (
    input  req0_valid, req0_addr, req0_taken,
    output req0_ready,
    input  req1_valid, req1_addr, req1_taken,
    output req1_ready,
    input  hold, flush,
    output update, update_addr, update_taken, pending
  );
endinterface

// File: rtl/cpu_branch_update_sched.sv
// Round-robin arbiter plus FIFO feeding the branch predictor's
// single update port, one update per cycle, with hold and flush.
module cpu_branch_update_sched #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  cpu_branch_update_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [XLEN:0] entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          prio;

  logic   deq;
  logic   space;
  logic   open;
  logic   grant0;
  logic   grant1;
  logic   enq;
  entry_t wdata;

  // rst_n gates the grants so nothing is accepted while reset is held
  always_comb begin
    deq    = (count != '0) && !bus.hold && !bus.flush;
    space  = (count < CW'(DEPTH)) || deq;
    open   = space && !bus.flush && rst_n;
    grant0 = open && bus.req0_valid
             && (!bus.req1_valid || !prio);
    grant1 = open && bus.req1_valid
             && (!bus.req0_valid || prio);
    enq    = grant0 || grant1;
    wdata  = '0;
    unique case (1'b1)
      grant1:  wdata = {bus.req1_addr, bus.req1_taken};
      default: wdata = {bus.req0_addr, bus.req0_taken};
    endcase
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.update       = deq;
  assign bus.update_addr  = mem[rd_ptr][XLEN:1];
  assign bus.update_taken = mem[rd_ptr][0];
  assign bus.pending      = count;

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      prio   <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count
               + {{AW{1'b0}}, enq}
               - {{AW{1'b0}}, deq};
      if (grant0) prio <= 1'b1;
      else if (grant1) prio <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_branch_update_sched.sv
// Self-checking bench: scenario tasks plus an in-order scoreboard
// of granted requests against predictor updates.
module tb_cpu_branch_update_sched;
  typedef logic [32:0] ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  ent_t sb[$];

  cpu_branch_update_sched_if #(.XLEN(32), .DEPTH(4)) bus ();

  cpu_branch_update_sched #(.XLEN(32), .DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: push on grant, pop on update
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.update) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow got=%h exp=none",
                   {bus.update_addr, bus.update_taken});
        end else begin
          ent_t e;
          e = sb.pop_front();
          if ({bus.update_addr, bus.update_taken} !== e) begin
            failures++;
            $display("FAIL sb_order got=%h exp=%h",
                     {bus.update_addr, bus.update_taken}, e);
          end
        end
      end
      if (bus.flush) sb.delete();
      checks++;
      if ((bus.req0_ready && bus.req1_ready) !== 1'b0) begin
        failures++;
        $display("FAIL one_grant got=%b%b exp=not 11",
                 bus.req0_ready, bus.req1_ready);
      end
      if (bus.req0_ready)
        sb.push_back({bus.req0_addr, bus.req0_taken});
      if (bus.req1_ready)
        sb.push_back({bus.req1_addr, bus.req1_taken});
    end
  end

  task automatic idle_inputs;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_taken = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_taken = 1'b0;
    bus.hold       = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic reset_dut;
    idle_inputs();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain;
    int c;
    c = 0;
    while ((bus.pending != 0 || sb.size() != 0) && c < 50) begin
      @(posedge clk);
      #1 c++;
    end
    checks++;
    if (bus.pending != 0 || sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d sb=%0d exp=0/0",
               bus.pending, sb.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 32'h44;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready0 got=%b exp=0", bus.req0_ready);
    end
    checks++;
    if (bus.pending !== 3'd0 || bus.update !== 1'b0) begin
      failures++;
      $display("FAIL rst_state pending=%0d update=%b exp=0/0",
               bus.pending, bus.update);
    end
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pending !== 3'd0 || bus.update !== 1'b0) begin
      failures++;
      $display("FAIL post_rst pending=%0d update=%b exp=0/0",
               bus.pending, bus.update);
    end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_ready got=%b%b exp=00",
               bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 32'h100;
    bus.req0_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got=%b exp=1", bus.req0_ready);
    end
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.update !== 1'b1 || bus.update_addr !== 32'h100
        || bus.update_taken !== 1'b1) begin
      failures++;
      $display("FAIL single_update got=%b/%h/%b exp=1/100/1",
               bus.update, bus.update_addr, bus.update_taken);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.update !== 1'b0 || bus.pending !== 3'd0) begin
      failures++;
      $display("FAIL single_after update=%b pending=%0d exp=0/0",
               bus.update, bus.pending);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alternate;
    logic [31:0] exp_up [4];
    logic        pm;
    exp_up[0] = 32'h10;
    exp_up[1] = 32'h20;
    exp_up[2] = 32'h14;
    exp_up[3] = 32'h24;
    reset_dut();
    pm = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 32'h10;
    bus.req0_taken = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 32'h20;
    bus.req1_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.req0_ready !== !pm || bus.req1_ready !== pm) begin
        failures++;
        $display("FAIL alt_grant%0d got=%b%b exp=%b%b", i,
                 bus.req0_ready, bus.req1_ready, !pm, pm);
      end
      if (i > 0) begin
        checks++;
        if (bus.update !== 1'b1 || bus.update_addr !== exp_up[i-1]
            || bus.pending > 3'd1) begin
          failures++;
          $display("FAIL alt_update%0d got=%b/%h/p%0d exp=1/%h/p<=1",
                   i, bus.update, bus.update_addr, bus.pending,
                   exp_up[i-1]);
        end
      end
      @(posedge clk);
      #1;
      if (!pm) bus.req0_addr = bus.req0_addr + 32'd4;
      else     bus.req1_addr = bus.req1_addr + 32'd4;
      pm = !pm;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.update !== 1'b1 || bus.update_addr !== exp_up[3]) begin
      failures++;
      $display("FAIL alt_update4 got=%b/%h exp=1/%h",
               bus.update, bus.update_addr, exp_up[3]);
    end
    @(posedge clk);
    #1 drain();
  endtask

  task automatic test_hold;
    int idx;
    reset_dut();
    idx = 0;
    bus.hold       = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 32'h200;
    bus.req0_taken = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (c < 4) begin
        if (bus.req0_ready !== 1'b1) begin
          failures++;
          $display("FAIL hold_accept%0d got=%b exp=1",
                   c, bus.req0_ready);
        end
      end else if (bus.req0_ready !== 1'b0 || bus.pending !== 3'd4
                   || bus.update !== 1'b0) begin
        failures++;
        $display("FAIL hold_full%0d rdy=%b p=%0d upd=%b exp=0/4/0",
                 c, bus.req0_ready, bus.pending, bus.update);
      end
      if (bus.req0_ready) idx++;
      @(posedge clk);
      #1 bus.req0_addr = 32'h200 + 32'(4 * idx);
    end
    bus.hold = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.update !== 1'b1) begin
        failures++;
        $display("FAIL hold_release%0d got=%b exp=1", c, bus.update);
      end
      if (bus.req0_ready) idx++;
      @(posedge clk);
      #1;
      if (idx >= 6) bus.req0_valid = 1'b0;
      else bus.req0_addr = 32'h200 + 32'(4 * idx);
    end
    checks++;
    if (idx !== 6) begin
      failures++;
      $display("FAIL hold_total got=%0d exp=6", idx);
    end
    drain();
  endtask

  task automatic test_full_wrap;
    int idx;
    int c;
    reset_dut();
    idx = 0;
    bus.hold       = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 32'h300;
    bus.req1_taken = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.req1_ready) idx++;
      @(posedge clk);
      #1 bus.req1_addr = 32'h300 + 32'(4 * idx);
      bus.req1_taken = bus.req1_addr[3];
    end
    @(negedge clk);
    checks++;
    if (bus.pending !== 3'd4 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_hold p=%0d rdy=%b exp=4/0",
               bus.pending, bus.req1_ready);
    end
    @(posedge clk);
    #1 bus.hold = 1'b0;
    c = 0;
    while (idx < 10 && c < 20) begin
      @(negedge clk);
      checks++;
      if (bus.pending !== 3'd4 || bus.update !== 1'b1
          || bus.req1_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_stream%0d p=%0d upd=%b rdy=%b exp=4/1/1",
                 c, bus.pending, bus.update, bus.req1_ready);
      end
      if (bus.req1_ready) idx++;
      c++;
      @(posedge clk);
      #1;
      if (idx >= 10) bus.req1_valid = 1'b0;
      bus.req1_addr  = 32'h300 + 32'(4 * idx);
      bus.req1_taken = bus.req1_addr[3];
    end
    bus.req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_flush;
    int idx;
    reset_dut();
    idx = 0;
    bus.hold       = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 32'h500;
    repeat (3) begin
      @(negedge clk);
      if (bus.req0_ready) idx++;
      @(posedge clk);
      #1 bus.req0_addr = 32'h500 + 32'(4 * idx);
    end
    checks++;
    if (bus.pending !== 3'd3) begin
      failures++;
      $display("FAIL flush_pre got=%0d exp=3", bus.pending);
    end
    bus.req0_addr  = 32'h400;
    bus.req0_taken = 1'b1;
    bus.flush      = 1'b1;
    bus.hold       = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.update !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle rdy=%b upd=%b exp=0/0",
               bus.req0_ready, bus.update);
    end
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pending !== 3'd0 || bus.update !== 1'b0
        || bus.req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_next p=%0d upd=%b rdy=%b exp=0/0/1",
               bus.pending, bus.update, bus.req0_ready);
    end
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.update !== 1'b1 || bus.update_addr !== 32'h400) begin
      failures++;
      $display("FAIL flush_resume got=%b/%h exp=1/400",
               bus.update, bus.update_addr);
    end
    @(posedge clk);
    #1 drain();
  endtask

  task automatic test_async_reset;
    reset_dut();
    bus.hold       = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 32'h600;
    bus.req0_taken = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 bus.req0_addr = bus.req0_addr + 32'd4;
    end
    bus.req0_valid = 1'b0;
    bus.hold       = 1'b0;
    #1;
    checks++;
    if (bus.update !== 1'b1 || bus.pending !== 3'd2) begin
      failures++;
      $display("FAIL arst_pre upd=%b p=%0d exp=1/2",
               bus.update, bus.pending);
    end
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (bus.update !== 1'b0 || bus.pending !== 3'd0) begin
      failures++;
      $display("FAIL arst_now upd=%b p=%0d exp=0/0",
               bus.update, bus.pending);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.update !== 1'b0 || bus.pending !== 3'd0) begin
        failures++;
        $display("FAIL arst_stale%0d upd=%b p=%0d exp=0/0",
                 c, bus.update, bus.pending);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_full_wrap();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
